// File: rtl/wb_traffic_master_if.sv
// ---------------------------------------------------------------------------
// wb_traffic_master_if
// Wishbone bus between the traffic master (initiator) and the SDRAM
// controller's Wishbone slave port.
//   wb_cyc_o, wb_stb_o, wb_we_o   cycle / strobe / write enable (master out)
//   wb_addr_o [AW]                byte address (master out)
//   wb_sel_o  [DW/8]              byte selects (master out)
//   wb_dat_o  [DW]                write data (master out)
//   wb_cti_o  [3], wb_bte_o [2]   burst cycle type / burst type (master out)
//   wb_dat_i  [DW], wb_ack_i      read data / acknowledge (slave out)
// ---------------------------------------------------------------------------
interface wb_traffic_master_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic            wb_cyc_o;
   logic            wb_stb_o;
   logic            wb_we_o;
   logic [AW-1:0]   wb_addr_o;
   logic [DW/8-1:0] wb_sel_o;
   logic [DW-1:0]   wb_dat_o;
   logic [2:0]      wb_cti_o;
   logic [1:0]      wb_bte_o;
   logic [DW-1:0]   wb_dat_i;
   logic            wb_ack_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o,
             wb_dat_o, wb_cti_o, wb_bte_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o,
             wb_dat_o, wb_cti_o, wb_bte_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/wb_traffic_master.sv
// ---------------------------------------------------------------------------
// wb_traffic_master
// Wishbone initiator for the test side of the wbi bus. Accepts one burst
// command at a time and issues an incrementing Wishbone burst. Writes carry
// the pattern P(k) = seed + k; reads are checked against the same pattern.
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_we, cmd_addr,      burst direction, start byte address,
//   cmd_len, cmd_seed      beat count (0 = no bus cycle), pattern seed
//   done, busy             end-of-command pulse, command in progress
//   err_cnt, fail_addr     saturating read-mismatch count, first bad address
//   timeout                sticky ack-timeout flag
//   wb                     Wishbone master modport
// ---------------------------------------------------------------------------
module wb_traffic_master #(
   parameter int DW   = 32,
   parameter int AW   = 32,
   parameter int LW   = 8,
   parameter int TO_W = 12
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
   input  logic [DW-1:0] cmd_seed,
   output logic          done,
   output logic          busy,
   output logic [15:0]   err_cnt,
   output logic [AW-1:0] fail_addr,
   output logic          timeout,
   wb_traffic_master_if.master wb
);

   typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, FIN = 2'd2} state_t;

   localparam logic [2:0] CTI_INC = 3'b010;
   localparam logic [2:0] CTI_END = 3'b111;
   // Terminal count is one below all-ones: counting from 0, this gives
   // 2^TO_W-1 consecutive no-ack strobe cycles before the burst is abandoned.
   localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   k_q, k_d;
   logic [DW-1:0]   seed_q, seed_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [15:0]     err_q, err_d;
   logic [AW-1:0]   fail_q, fail_d;
   logic            tmo_q, tmo_d;
   logic            act_q, act_d;
   logic            bwe_q, bwe_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic [2:0]      cti_q, cti_d;

   logic [DW-1:0]   pat;
   logic            ack_ok;
   logic            last_beat;
   logic            drop_bus;

   assign pat       = seed_q + DW'(k_q);
   assign ack_ok    = wb.wb_ack_i & act_q;
   assign last_beat = (k_q == len_q - LW'(1));

   // Next-state and next-value logic. Bus outputs are computed one cycle
   // ahead so that the registered address/data/cti for beat k+1 appear
   // immediately after the ack of beat k, giving one beat per cycle.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      len_d    = len_q;
      k_d      = k_q;
      seed_d   = seed_q;
      to_d     = to_q;
      err_d    = err_q;
      fail_d   = fail_q;
      tmo_d    = tmo_q;
      act_d    = act_q;
      bwe_d    = bwe_q;
      addr_d   = addr_q;
      dat_d    = dat_q;
      cti_d    = cti_q;
      drop_bus = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               we_d   = cmd_we;
               len_d  = cmd_len;
               seed_d = cmd_seed;
               k_d    = '0;
               to_d   = '0;
               if (cmd_len != '0) begin
                  state_d = BURST;
                  act_d   = 1'b1;
                  bwe_d   = cmd_we;
                  addr_d  = cmd_addr & ~AW'(3);
                  dat_d   = cmd_we ? cmd_seed : '0;
                  cti_d   = (cmd_len == LW'(1)) ? CTI_END : CTI_INC;
               end else begin
                  state_d = FIN;
               end
            end
         end
         BURST: begin
            if (ack_ok) begin
               to_d = '0;
               // Only the first mismatch since reset records its address.
               if (!we_q && (wb.wb_dat_i != pat)) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  if (err_q == 16'd0)    fail_d = addr_q;
               end
               if (last_beat) begin
                  state_d  = FIN;
                  drop_bus = 1'b1;
               end else begin
                  k_d    = k_q + LW'(1);
                  addr_d = addr_q + AW'(4);
                  dat_d  = we_q ? (pat + DW'(1)) : '0;
                  cti_d  = ((k_q + LW'(2)) == len_q) ? CTI_END : CTI_INC;
               end
            end else if (to_q == TO_LAST) begin
               tmo_d    = 1'b1;
               state_d  = FIN;
               drop_bus = 1'b1;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            drop_bus = 1'b1;
         end
      endcase

      if (drop_bus) begin
         act_d  = 1'b0;
         bwe_d  = 1'b0;
         addr_d = '0;
         dat_d  = '0;
         cti_d  = '0;
      end
   end

   // State and datapath registers; reset abandons any burst in flight.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         len_q   <= '0;
         k_q     <= '0;
         seed_q  <= '0;
         to_q    <= '0;
         err_q   <= '0;
         fail_q  <= '0;
         tmo_q   <= 1'b0;
         act_q   <= 1'b0;
         bwe_q   <= 1'b0;
         addr_q  <= '0;
         dat_q   <= '0;
         cti_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         len_q   <= len_d;
         k_q     <= k_d;
         seed_q  <= seed_d;
         to_q    <= to_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         tmo_q   <= tmo_d;
         act_q   <= act_d;
         bwe_q   <= bwe_d;
         addr_q  <= addr_d;
         dat_q   <= dat_d;
         cti_q   <= cti_d;
      end
   end

   assign cmd_ready    = (state_q == IDLE);
   assign done         = (state_q == FIN);
   assign busy         = (state_q != IDLE);
   assign err_cnt      = err_q;
   assign fail_addr    = fail_q;
   assign timeout      = tmo_q;

   assign wb.wb_cyc_o  = act_q;
   assign wb.wb_stb_o  = act_q;
   assign wb.wb_we_o   = bwe_q;
   assign wb.wb_addr_o = addr_q;
   assign wb.wb_sel_o  = {(DW/8){act_q}};
   assign wb.wb_dat_o  = dat_q;
   assign wb.wb_cti_o  = cti_q;
   assign wb.wb_bte_o  = 2'b00;

endmodule

// File: tb/tb_wb_traffic_master.sv
// ---------------------------------------------------------------------------
// tb_wb_traffic_master
// Drives wb_traffic_master against a behavioural Wishbone slave memory with
// programmable wait states / ack suppression, and compares every burst with
// a command-level reference model (expected beat list, pattern memory,
// saturating error count, first failing address, sticky timeout).
// ---------------------------------------------------------------------------
module tb_wb_traffic_master;

   localparam logic [31:0] DEFAULT = 32'hDEAD_BEEF;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [31:0] seed;
      int          waits;
      logic [15:0] exp_err;
      logic [31:0] exp_fail;
      int          exp_stb;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] dat;
      logic [2:0]  cti;
      logic        we;
      logic [3:0]  sel;
      logic [1:0]  bte;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_addr, cmd_seed;
   logic [7:0]  cmd_len;
   logic        done, busy, timeout;
   logic [15:0] err_cnt;
   logic [31:0] fail_addr;

   wb_traffic_master_if #(.DW(32), .AW(32)) wb_bus ();

   wb_traffic_master #(.DW(32), .AW(32), .LW(8), .TO_W(4)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_seed  (cmd_seed),
      .done      (done),
      .busy      (busy),
      .err_cnt   (err_cnt),
      .fail_addr (fail_addr),
      .timeout   (timeout),
      .wb        (wb_bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle = 0;

   always @(posedge clk) cycle <= cycle + 1;

   // Slave: combinational ack after 'waits' stall cycles per beat.
   int  waits = 0;
   bit  ack_en = 1'b1;
   int  wait_cnt = 0;
   logic [31:0] smem [0:4095];

   always @(posedge clk) begin
      if (!(wb_bus.wb_cyc_o && wb_bus.wb_stb_o) || wb_bus.wb_ack_i) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   assign wb_bus.wb_ack_i = wb_bus.wb_cyc_o & wb_bus.wb_stb_o & ack_en & (wait_cnt >= waits);
   assign wb_bus.wb_dat_i = smem[wb_bus.wb_addr_o[13:2]];

   // Bus monitor: per-command statistics, beat log and slave memory writes.
   int    clear_seq = 0;
   int    seen_seq = 0;
   bit    mem_ready = 1'b0;
   beat_t beat_log[$];
   int    stb_cycles, cyc_cycles, first_stb, last_ack, done_cyc, done_cnt, stab_err;
   bit    busy_at_done, in_beat;
   logic [31:0] hold_addr, hold_dat;
   logic [2:0]  hold_cti;
   logic        hold_we;

   always @(negedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 4096; i++) smem[i] = DEFAULT;
         mem_ready = 1'b1;
      end
      if (seen_seq != clear_seq) begin
         seen_seq = clear_seq;
         beat_log.delete();
         stb_cycles = 0; cyc_cycles = 0; first_stb = -1; last_ack = -1;
         done_cyc = -1; done_cnt = 0; stab_err = 0; busy_at_done = 1'b0;
      end
      if (wb_bus.wb_cyc_o) cyc_cycles++;
      if (wb_bus.wb_stb_o) begin
         stb_cycles++;
         if (first_stb < 0) first_stb = cycle;
         if (!in_beat) begin
            hold_addr = wb_bus.wb_addr_o; hold_dat = wb_bus.wb_dat_o;
            hold_cti = wb_bus.wb_cti_o;   hold_we = wb_bus.wb_we_o;
            in_beat = 1'b1;
         end else if ({wb_bus.wb_addr_o, wb_bus.wb_dat_o, wb_bus.wb_cti_o, wb_bus.wb_we_o}
                      !== {hold_addr, hold_dat, hold_cti, hold_we}) begin
            stab_err++;
         end
         if (wb_bus.wb_ack_i) begin
            beat_log.push_back('{addr: wb_bus.wb_addr_o, dat: wb_bus.wb_dat_o,
                                 cti: wb_bus.wb_cti_o, we: wb_bus.wb_we_o,
                                 sel: wb_bus.wb_sel_o, bte: wb_bus.wb_bte_o});
            if (wb_bus.wb_we_o) smem[wb_bus.wb_addr_o[13:2]] = wb_bus.wb_dat_o;
            last_ack = cycle;
            in_beat = 1'b0;
         end
      end else begin
         in_beat = 1'b0;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cycle;
         busy_at_done = busy;
      end
   end

   // Reference model: word memory keyed by byte address plus status.
   logic [31:0] mmem [logic [31:0]];
   logic [15:0] m_err = 16'd0;
   logic [31:0] m_fail = 32'd0;
   bit          m_tmo = 1'b0;
   int          accept_cyc;

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      return mmem.exists(a) ? mmem[a] : DEFAULT;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic clearMonitor();
      clear_seq++;
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit we, input logic [31:0] addr,
                                input logic [7:0] len, input logic [31:0] seed);
      int n;
      clearMonitor();
      cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_seed = seed;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      accept_cyc = cycle;
      if (!cmd_ready) checkOutput("accept_wait", 0, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_we = 1'($urandom); cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_seed = $urandom;
      #1;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         @(negedge clk); #1; n++;
      end
      if (done_cnt == 0) checkOutput("done_wait", 0, 1);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic runCmd(input string tag, input bit we, input logic [31:0] addr,
                         input logic [7:0] len, input logic [31:0] seed,
                         input int w, input bit acken);
      logic [31:0] base, ea, p;
      bit stalled;
      int nb, exp_stb;
      waits = w;
      ack_en = acken;
      applyStimulus(we, addr, len, seed);
      base = addr & ~32'd3;
      stalled = (len != 0) && !acken;
      nb = stalled ? 0 : int'(len);
      exp_stb = stalled ? 15 : int'(len) * (w + 1);
      checkOutput({tag, " beats"}, beat_log.size(), nb);
      for (int k = 0; k < nb && k < beat_log.size(); k++) begin
         ea = base + 32'(4 * k);
         p = seed + 32'(k);
         checkOutput($sformatf("%s addr%0d", tag, k), beat_log[k].addr, ea);
         checkOutput($sformatf("%s cti%0d", tag, k), beat_log[k].cti, (k == nb - 1) ? 3'b111 : 3'b010);
         checkOutput($sformatf("%s we%0d", tag, k), beat_log[k].we, we);
         checkOutput($sformatf("%s sel%0d", tag, k), {beat_log[k].sel, beat_log[k].bte}, 6'b1111_00);
         if (we) checkOutput($sformatf("%s dat%0d", tag, k), beat_log[k].dat, p);
      end
      if (stalled) m_tmo = 1'b1;
      else begin
         for (int k = 0; k < int'(len); k++) begin
            ea = base + 32'(4 * k);
            p = seed + 32'(k);
            if (we) mmem[ea] = p;
            else if (modelRead(ea) != p) begin
               if (m_err == 16'd0) m_fail = ea;
               if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            end
         end
      end
      checkOutput({tag, " err_cnt"}, err_cnt, m_err);
      checkOutput({tag, " fail_addr"}, fail_addr, m_fail);
      checkOutput({tag, " timeout"}, timeout, m_tmo);
      checkOutput({tag, " stb_cycles"}, stb_cycles, exp_stb);
      checkOutput({tag, " cyc_cycles"}, cyc_cycles, exp_stb);
      checkOutput({tag, " done_count"}, done_cnt, 1);
      checkOutput({tag, " busy_at_done"}, busy_at_done, 1);
      checkOutput({tag, " stable"}, stab_err, 0);
      checkOutput({tag, " idle_after"}, {cmd_ready, busy}, 2'b10);
      if (len == 0) checkOutput({tag, " done_lat"}, done_cyc, accept_cyc + 1);
      else begin
         checkOutput({tag, " first_stb"}, first_stb, accept_cyc + 1);
         if (stalled) checkOutput({tag, " done_lat"}, done_cyc, first_stb + 15);
         else         checkOutput({tag, " done_lat"}, done_cyc, last_ack + 1);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " ready_busy_done"}, {cmd_ready, busy, done}, 3'b100);
      checkOutput({tag, " err_fail_to"}, {err_cnt, fail_addr, timeout}, 49'd0);
      checkOutput({tag, " cyc_stb_we"}, {wb_bus.wb_cyc_o, wb_bus.wb_stb_o, wb_bus.wb_we_o}, 3'b000);
      checkOutput({tag, " addr"}, wb_bus.wb_addr_o, 32'd0);
      checkOutput({tag, " dat"}, wb_bus.wb_dat_o, 32'd0);
      checkOutput({tag, " sel_cti_bte"}, {wb_bus.wb_sel_o, wb_bus.wb_cti_o, wb_bus.wb_bte_o}, 9'd0);
   endtask

   vec_t vecs[8];

   initial begin
      int n, iter;
      logic [31:0] ra;
      vecs[0] = '{1'b1, 32'h100, 8'd4, 32'hA5A50000, 0, 16'd0, 32'h0,   4};
      vecs[1] = '{1'b0, 32'h100, 8'd4, 32'hA5A50000, 0, 16'd0, 32'h0,   4};
      vecs[2] = '{1'b0, 32'h100, 8'd4, 32'hA5A50001, 0, 16'd4, 32'h100, 4};
      vecs[3] = '{1'b1, 32'h200, 8'd2, 32'h11110000, 3, 16'd4, 32'h100, 8};
      vecs[4] = '{1'b1, 32'h240, 8'd0, 32'h00000000, 0, 16'd4, 32'h100, 0};
      vecs[5] = '{1'b0, 32'h200, 8'd2, 32'h11110000, 3, 16'd4, 32'h100, 8};
      vecs[6] = '{1'b0, 32'h102, 8'd4, 32'hA5A50000, 1, 16'd4, 32'h100, 8};
      vecs[7] = '{1'b0, 32'h204, 8'd2, 32'h11110000, 0, 16'd6, 32'h100, 2};

      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
      cmd_addr = '0; cmd_len = '0; cmd_seed = '0;
      repeat (3) @(negedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b0;

      $display("[TB] directed vectors");
      for (int i = 0; i < 8; i++) begin
         runCmd($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].len,
                vecs[i].seed, vecs[i].waits, 1'b1);
         checkOutput($sformatf("vec%0d tbl_err", i), err_cnt, vecs[i].exp_err);
         checkOutput($sformatf("vec%0d tbl_fail", i), fail_addr, vecs[i].exp_fail);
         checkOutput($sformatf("vec%0d tbl_stb", i), stb_cycles, vecs[i].exp_stb);
      end

      $display("[TB] randomized commands");
      for (int i = 0; i < 30; i++) begin
         ra = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         runCmd($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), ra,
                8'($urandom_range(0, 8)),
                32'h00C0_0000 + (ra >> 2) + 32'($urandom_range(0, 3) == 0),
                $urandom_range(0, 2), 1'b1);
      end

      $display("[TB] ack timeout");
      runCmd("tmo", 1'b0, 32'h3800, 8'd3, 32'h0, 0, 1'b0);
      runCmd("tmo_sticky", 1'b1, 32'h3900, 8'd1, 32'h1234, 0, 1'b1);

      $display("[TB] error counter saturation");
      iter = 0;
      while (m_err != 16'hFFFF && iter < 300) begin
         runCmd("sat", 1'b0, 32'h2000, 8'd255, 32'h0, 0, 1'b1);
         iter++;
      end
      checkOutput("sat_level", err_cnt, 16'hFFFF);
      runCmd("sat_more", 1'b0, 32'h2000, 8'd255, 32'h0, 0, 1'b1);
      checkOutput("sat_hold", err_cnt, 16'hFFFF);
      checkOutput("sat_fail", fail_addr, 32'h100);

      $display("[TB] reset during burst");
      waits = 0; ack_en = 1'b1;
      clearMonitor();
      cmd_we = 1'b1; cmd_addr = 32'h3000; cmd_len = 8'd8; cmd_seed = 32'h9000;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      n = 0;
      while (beat_log.size() < 1 && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (beat_log.size() < 1) checkOutput("rst_wait_beat", 0, 1);
      @(negedge clk); #1;
      checkOutput("rst_beat2_addr", wb_bus.wb_addr_o, 32'h3004);
      rst = 1'b1;
      @(negedge clk); #1;
      checkResetState("rst_mid");
      rst = 1'b0;
      m_err = 16'd0; m_fail = 32'd0; m_tmo = 1'b0;

      runCmd("wrap_wr", 1'b1, 32'hFFFF_FFFC, 8'd2, 32'h77, 0, 1'b1);
      if (beat_log.size() >= 2) checkOutput("wrap_second_addr", beat_log[1].addr, 32'h0);
      else checkOutput("wrap_second_beat", beat_log.size(), 2);
      runCmd("wrap_rd", 1'b0, 32'hFFFF_FFFC, 8'd2, 32'h77, 1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
